// File: rtl/l2_lookup_sched.sv
// l2_lookup_sched: arbitrates CPU requests and forward/probe lookups onto the
// L2 tag/state read path, sequences read -> lookup -> response, and returns the
// lookup-stage result over a valid/ready handshake.
// Optional feature macro: L2_LOOKUP_STARVE_GUARD_EN (forces a pending request
// through after STARVE_LIMIT consecutive forward grants).
module l2_lookup_sched #(
  parameter int unsigned LINE_ADDR_BITS = 26,
  parameter int unsigned L2_SET_BITS    = 9,
  parameter int unsigned L2_WAY_BITS    = 3,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // CPU-side request source
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LINE_ADDR_BITS-1:0] req_line_addr,
  // Forward/probe source
  input  logic                      fwd_valid,
  output logic                      fwd_ready,
  input  logic [LINE_ADDR_BITS-1:0] fwd_line_addr,
  // Tag/state array read
  output logic                      rd_en,
  output logic [L2_SET_BITS-1:0]    rd_set,
  // Lookup stage control
  output logic [LINE_ADDR_BITS-1:0] lkp_line_addr,
  output logic                      lookup_en,
  output logic                      lookup_mode,
  input  logic                      tag_hit,
  input  logic [L2_WAY_BITS-1:0]    way_hit,
  input  logic                      empty_way_found,
  input  logic [L2_WAY_BITS-1:0]    empty_way,
  // Result return
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_is_fwd,
  output logic                      resp_tag_hit,
  output logic [L2_WAY_BITS-1:0]    resp_way,
  output logic                      resp_empty_found,
  output logic [L2_WAY_BITS-1:0]    resp_empty_way
);

  localparam logic L2_LOOKUP     = 1'b0;
  localparam logic L2_LOOKUP_FWD = 1'b1;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StLookup,
    StResp
  } state_e;

  state_e                    state_q;
  logic                      src_fwd_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic                      rd_en_q;
  logic                      lookup_en_q;
  logic                      resp_valid_q;

  logic                      starve_force;
  logic                      fwd_win;
  logic                      req_win;

`ifdef L2_LOOKUP_STARVE_GUARD_EN
  logic [3:0] starve_q;

  // Request overrides forward priority once the forward streak hits the limit.
  assign starve_force = req_valid && (starve_q == StarveMax);

  // Count forward grants that bypass a waiting request; any request grant clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (req_win) begin
      starve_q <= 4'd0;
    end else if (fwd_win && req_valid && (starve_q != StarveMax)) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  logic unused_starve_limit;

  // Strict forward priority: requests can starve behind a forward stream.
  assign starve_force        = 1'b0;
  assign unused_starve_limit = ^StarveMax;
`endif

  // Grant selection: only in idle and never while reset is asserted.
  always_comb begin
    fwd_win = 1'b0;
    req_win = 1'b0;
    if ((state_q == StIdle) && !rst) begin
      if (fwd_valid && !starve_force) begin
        fwd_win = 1'b1;
      end else if (req_valid) begin
        req_win = 1'b1;
      end
    end
  end

  assign fwd_ready = fwd_win;
  assign req_ready = req_win;

  // Sequencer: accept -> array read -> lookup -> hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      src_fwd_q    <= 1'b0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      lookup_en_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fwd_win || req_win) begin
            addr_q    <= fwd_win ? fwd_line_addr : req_line_addr;
            src_fwd_q <= fwd_win;
            rd_en_q   <= 1'b1;
            state_q   <= StRead;
          end
        end
        StRead: begin
          rd_en_q     <= 1'b0;
          lookup_en_q <= 1'b1;
          state_q     <= StLookup;
        end
        StLookup: begin
          lookup_en_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
      endcase
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_set        = addr_q[L2_SET_BITS-1:0];
  assign lkp_line_addr = addr_q;
  assign lookup_en     = lookup_en_q;
  assign lookup_mode   = src_fwd_q ? L2_LOOKUP_FWD : L2_LOOKUP;

  // Lookup-stage outputs hold while lookup_en is low, so they pass straight
  // through during the response; empty-way info is meaningless for forwards.
  assign resp_valid       = resp_valid_q;
  assign resp_is_fwd      = resp_valid_q & src_fwd_q;
  assign resp_tag_hit     = resp_valid_q & tag_hit;
  assign resp_way         = resp_valid_q ? way_hit : '0;
  assign resp_empty_found = resp_valid_q & ~src_fwd_q & empty_way_found;
  assign resp_empty_way   = (resp_valid_q && !src_fwd_q) ? empty_way : '0;

endmodule

// File: tb/tb_l2_lookup_sched.sv
// Testbench for l2_lookup_sched: directed scenarios followed by random traffic,
// checked against a transaction-level model of the lookup scheduler.
module tb_l2_lookup_sched;

  localparam int unsigned LAB   = 26;
  localparam int unsigned SB    = 9;
  localparam int unsigned WB    = 3;
  localparam int          LIMIT = 4;
`ifdef L2_LOOKUP_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, fwd_valid, fwd_ready;
  logic [LAB-1:0] req_line_addr, fwd_line_addr, lkp_line_addr;
  logic           rd_en, lookup_en, lookup_mode;
  logic [SB-1:0]  rd_set;
  logic           resp_valid, resp_ready, resp_is_fwd, resp_tag_hit, resp_empty_found;
  logic [WB-1:0]  resp_way, resp_empty_way;

  // Lookup stage model: registers fresh results when enabled, holds otherwise.
  logic           lk_tag_hit = 1'b0;
  logic [WB-1:0]  lk_way = '0;
  logic           lk_ef = 1'b0;
  logic [WB-1:0]  lk_ew = '0;
  logic           nx_tag_hit;
  logic [WB-1:0]  nx_way;
  logic           nx_ef;
  logic [WB-1:0]  nx_ew;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lookup_en) begin
      lk_tag_hit <= nx_tag_hit;
      lk_way     <= nx_way;
      lk_ef      <= nx_ef;
      lk_ew      <= nx_ew;
    end
  end

  l2_lookup_sched #(
    .LINE_ADDR_BITS(LAB),
    .L2_SET_BITS   (SB),
    .L2_WAY_BITS   (WB),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_line_addr   (req_line_addr),
    .fwd_valid       (fwd_valid),
    .fwd_ready       (fwd_ready),
    .fwd_line_addr   (fwd_line_addr),
    .rd_en           (rd_en),
    .rd_set          (rd_set),
    .lkp_line_addr   (lkp_line_addr),
    .lookup_en       (lookup_en),
    .lookup_mode     (lookup_mode),
    .tag_hit         (lk_tag_hit),
    .way_hit         (lk_way),
    .empty_way_found (lk_ef),
    .empty_way       (lk_ew),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_is_fwd     (resp_is_fwd),
    .resp_tag_hit    (resp_tag_hit),
    .resp_way        (resp_way),
    .resp_empty_found(resp_empty_found),
    .resp_empty_way  (resp_empty_way)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one transaction in flight, tracked by its age in cycles.
  bit           m_busy = 1'b0;
  int           m_age = 0;
  bit           m_src = 1'b0;
  logic [LAB-1:0] m_addr = '0;
  int           m_streak = 0;
  bit           e_req, e_fwd;
  bit           s_req, s_fwd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    e_fwd = 1'b0;
    e_req = 1'b0;
    if (!m_busy && !rst) begin
      e_fwd = fwd_valid && !(GUARD && req_valid && (m_streak == LIMIT));
      e_req = req_valid && !e_fwd;
    end
    s_req = req_ready;
    s_fwd = fwd_ready;
    check("fwd_ready", 32'(fwd_ready), 32'(e_fwd));
    check("req_ready", 32'(req_ready), 32'(e_req));
    check("rd_en", 32'(rd_en), 32'(m_busy && m_age == 1));
    if (m_busy && m_age == 1) check("rd_set", 32'(rd_set), 32'(m_addr[SB-1:0]));
    check("lookup_en", 32'(lookup_en), 32'(m_busy && m_age == 2));
    if (m_busy && m_age == 2) check("lookup_mode", 32'(lookup_mode), 32'(m_src));
    check("resp_valid", 32'(resp_valid), 32'(m_busy && m_age >= 3));
    if (m_busy) check("lkp_line_addr", 32'(lkp_line_addr), 32'(m_addr));
    if (m_busy && m_age >= 3) begin
      check("resp_is_fwd", 32'(resp_is_fwd), 32'(m_src));
      check("resp_tag_hit", 32'(resp_tag_hit), 32'(lk_tag_hit));
      check("resp_way", 32'(resp_way), 32'(lk_way));
      check("resp_empty_found", 32'(resp_empty_found), 32'(m_src ? 1'b0 : lk_ef));
      check("resp_empty_way", 32'(resp_empty_way), 32'(m_src ? '0 : lk_ew));
    end
  endtask

  task automatic update_model();
    if (rst) begin
      m_busy = 1'b0;
      m_src = 1'b0;
      m_addr = '0;
      m_streak = 0;
    end else if (!m_busy) begin
      if (e_fwd) begin
        m_busy = 1'b1;
        m_age = 1;
        m_src = 1'b1;
        m_addr = fwd_line_addr;
        if (GUARD && req_valid && m_streak < LIMIT) m_streak++;
      end else if (e_req) begin
        m_busy = 1'b1;
        m_age = 1;
        m_src = 1'b0;
        m_addr = req_line_addr;
        m_streak = 0;
      end
    end else if (m_age >= 3 && resp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic pre();
    #1;
    check_outputs();
  endtask

  task automatic post();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic run_cycle();
    pre();
    post();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_lookup_en"}, 32'(lookup_en), 32'd0);
    check({tag, "_lookup_mode"}, 32'(lookup_mode), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_is_fwd"}, 32'(resp_is_fwd), 32'd0);
    check({tag, "_lkp_line_addr"}, 32'(lkp_line_addr), 32'd0);
    check({tag, "_resp_tag_hit"}, 32'(resp_tag_hit), 32'd0);
    check({tag, "_resp_way"}, 32'(resp_way), 32'd0);
    check({tag, "_resp_empty_found"}, 32'(resp_empty_found), 32'd0);
    check({tag, "_resp_empty_way"}, 32'(resp_empty_way), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           snap_tag, snap_ef, snap_fwd;
    logic [WB-1:0]  snap_way, snap_ew;
    logic [LAB-1:0] snap_addr;
    bit             grant_fwd[10];
    int             n_grants;
    int             budget;

    rst = 1'b1;
    req_valid = 1'b1;
    fwd_valid = 1'b1;
    req_line_addr = '0;
    fwd_line_addr = '0;
    resp_ready = 1'b1;
    nx_tag_hit = 1'b0; nx_way = '0; nx_ef = 1'b0; nx_ew = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with both sources valid: ready must stay low under reset.
    check_reset_outputs("reset");
    run_cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    fwd_valid = 1'b0;
    run_cycle();

    // Single request at 0x1234 with an injected hit in way 5.
    nx_tag_hit = 1'b1; nx_way = 3'd5; nx_ef = 1'b1; nx_ew = 3'd2;
    req_valid = 1'b1;
    req_line_addr = 26'h1234;
    pre();
    check("t1_req_ready", 32'(req_ready), 32'd1);
    post();
    req_valid = 1'b0;
    pre();
    check("t1_rd_en", 32'(rd_en), 32'd1);
    check("t1_rd_set", 32'(rd_set), 32'h034);
    post();
    pre();
    check("t1_lookup_en", 32'(lookup_en), 32'd1);
    check("t1_lookup_mode", 32'(lookup_mode), 32'd0);
    post();
    pre();
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_tag_hit", 32'(resp_tag_hit), 32'd1);
    check("t1_resp_way", 32'(resp_way), 32'd5);
    check("t1_resp_empty_way", 32'(resp_empty_way), 32'd2);
    post();

    // Simultaneous sources: forward first, then the request on the next idle.
    nx_tag_hit = 1'b0; nx_way = 3'd1; nx_ef = 1'b1; nx_ew = 3'd3;
    req_valid = 1'b1; req_line_addr = 26'h0ABCD;
    fwd_valid = 1'b1; fwd_line_addr = 26'h3F00F;
    pre();
    check("t2_fwd_ready", 32'(fwd_ready), 32'd1);
    check("t2_req_ready", 32'(req_ready), 32'd0);
    post();
    fwd_valid = 1'b0;
    run_cycle();
    pre();
    check("t2_lookup_mode", 32'(lookup_mode), 32'd1);
    post();
    pre();
    check("t2_resp_is_fwd", 32'(resp_is_fwd), 32'd1);
    check("t2_resp_empty_found", 32'(resp_empty_found), 32'd0);
    check("t2_resp_empty_way", 32'(resp_empty_way), 32'd0);
    post();
    pre();
    check("t2_req_ready_next", 32'(req_ready), 32'd1);
    post();
    req_valid = 1'b0;
    repeat (3) run_cycle();

    // Backpressure: hold the response for 10 cycles with a forward waiting.
    nx_tag_hit = 1'b1; nx_way = 3'd6; nx_ef = 1'b0; nx_ew = 3'd4;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_line_addr = 26'h2A5A5;
    run_cycle();
    req_valid = 1'b0;
    fwd_valid = 1'b1; fwd_line_addr = 26'h11111;
    repeat (2) run_cycle();
    pre();
    snap_tag = resp_tag_hit; snap_way = resp_way; snap_ef = resp_empty_found;
    snap_ew = resp_empty_way; snap_fwd = resp_is_fwd; snap_addr = lkp_line_addr;
    check("t3_first_resp_way", 32'(resp_way), 32'd6);
    post();
    for (int i = 0; i < 9; i++) begin
      pre();
      check("t3_hold_valid", 32'(resp_valid), 32'd1);
      check("t3_hold_tag", 32'(resp_tag_hit), 32'(snap_tag));
      check("t3_hold_way", 32'(resp_way), 32'(snap_way));
      check("t3_hold_ef", 32'(resp_empty_found), 32'(snap_ef));
      check("t3_hold_ew", 32'(resp_empty_way), 32'(snap_ew));
      check("t3_hold_fwd", 32'(resp_is_fwd), 32'(snap_fwd));
      check("t3_hold_addr", 32'(lkp_line_addr), 32'(snap_addr));
      check("t3_hold_readies", 32'({fwd_ready, req_ready}), 32'd0);
      post();
    end
    resp_ready = 1'b1;
    pre();
    check("t3_handshake_valid", 32'(resp_valid), 32'd1);
    post();
    pre();
    check("t3_idle_fwd_ready", 32'(fwd_ready), 32'd1);
    post();
    fwd_valid = 1'b0;
    repeat (3) run_cycle();

    // Starvation: both sources held valid across ten grants after a clean reset.
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    req_valid = 1'b1;
    fwd_valid = 1'b1;
    n_grants = 0;
    budget = 0;
    while (n_grants < 10 && budget < 200) begin
      req_line_addr = LAB'($urandom);
      fwd_line_addr = LAB'($urandom);
      pre();
      if (s_fwd || s_req) begin
        grant_fwd[n_grants] = s_fwd;
        n_grants++;
      end
      post();
      budget++;
    end
    check("t4_grant_count", 32'(n_grants), 32'd10);
    for (int i = 0; i < n_grants; i++) begin
      check("t4_grant_is_fwd", 32'(grant_fwd[i]),
            32'(!(GUARD && ((i % (LIMIT + 1)) == LIMIT))));
    end
    req_valid = 1'b0;
    fwd_valid = 1'b0;
    repeat (4) run_cycle();

    // Reset while the lookup is in progress: the transaction vanishes.
    req_valid = 1'b1; req_line_addr = 26'h0777;
    run_cycle();
    req_valid = 1'b0;
    run_cycle();
    rst = 1'b1;
    pre();
    check("t5_lookup_en_before_rst", 32'(lookup_en), 32'd1);
    post();
    rst = 1'b0;
    pre();
    check_reset_outputs("t5");
    post();
    for (int i = 0; i < 5; i++) begin
      pre();
      check("t5_no_resp", 32'(resp_valid), 32'd0);
      post();
    end

    // Random traffic: sources hold valid until accepted, random backpressure/reset.
    for (int i = 0; i < 600; i++) begin
      if (!req_valid || e_req) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_line_addr = LAB'($urandom);
      end
      if (!fwd_valid || e_fwd) begin
        fwd_valid = ($urandom_range(0, 3) == 0);
        fwd_line_addr = LAB'($urandom);
      end
      resp_ready = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 99) == 0);
      nx_tag_hit = 1'($urandom);
      nx_way = WB'($urandom);
      nx_ef = 1'($urandom);
      nx_ew = WB'($urandom);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
